// File: rtl/hack_pkg.sv
// Shared constants for the Hack CPU core: word width and instruction bit positions.
// Optional debug ports are enabled by defining HACK_CPU_DEBUG_EN.
package hack_pkg;
    localparam int WORD_W    = 16;

    localparam int INST_TYPE = 15;
    localparam int A_SEL     = 12;
    localparam int COMP_MSB  = 11;
    localparam int COMP_LSB  = 6;
    localparam int DEST_A    = 5;
    localparam int DEST_D    = 4;
    localparam int DEST_M    = 3;
    localparam int J_LT      = 2;
    localparam int J_EQ      = 1;
    localparam int J_GT      = 0;
endpackage

// File: rtl/hack_alu.sv
// Hack ALU: purely combinational; conditions both operands, then adds or ANDs,
// then optionally inverts. Flags describe the final result.
module hack_alu
    import hack_pkg::*;
(
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] y,
    input  logic              zx,
    input  logic              nx,
    input  logic              zy,
    input  logic              ny,
    input  logic              f,
    input  logic              no,
    output logic [WORD_W-1:0] out,
    output logic              zr,
    output logic              ng
);
    logic [WORD_W-1:0] x1, x2, y1, y2, o;

    // Operand conditioning, function select and output inversion.
    always_comb begin
        x1  = zx ? '0 : x;
        x2  = nx ? ~x1 : x1;
        y1  = zy ? '0 : y;
        y2  = ny ? ~y1 : y1;
        o   = f ? (x2 + y2) : (x2 & y2);
        out = no ? ~o : o;
        zr  = (out == '0);
        ng  = out[WORD_W-1];
    end
endmodule

// File: rtl/hack_cpu.sv
// Hack 16-bit CPU core: A/D registers, program counter and the Hack ALU.
// One instruction per rising clock edge; asynchronous active-low reset.
// Define HACK_CPU_DEBUG_EN to expose dbg_a, dbg_d and dbg_jump.
module hack_cpu
    import hack_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] instruction,
    input  logic [WORD_W-1:0] inM,
    output logic [WORD_W-1:0] outM,
    output logic              writeM,
    output logic [ADDR_W-1:0] addressM,
`ifdef HACK_CPU_DEBUG_EN
    output logic [WORD_W-1:0] dbg_a,
    output logic [WORD_W-1:0] dbg_d,
    output logic              dbg_jump,
`endif
    output logic [ADDR_W-1:0] pc
);
    logic [WORD_W-1:0] a_q, a_d;
    logic [WORD_W-1:0] d_q, d_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    logic              is_c;
    logic [WORD_W-1:0] alu_y;
    logic [WORD_W-1:0] alu_out;
    logic              alu_zr, alu_ng;
    logic              take;

    // Bits 14:13 of a C-instruction carry no meaning.
    logic unused_inst_bits;
    assign unused_inst_bits = ^instruction[14:13];

    hack_alu u_alu (
        .x   (d_q),
        .y   (alu_y),
        .zx  (instruction[COMP_MSB]),
        .nx  (instruction[COMP_MSB-1]),
        .zy  (instruction[COMP_MSB-2]),
        .ny  (instruction[COMP_MSB-3]),
        .f   (instruction[COMP_MSB-4]),
        .no  (instruction[COMP_LSB]),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    // Decode, jump decision and next-state selection; all from pre-edge A/D.
    always_comb begin
        is_c  = instruction[INST_TYPE];
        alu_y = instruction[A_SEL] ? inM : a_q;
        take  = is_c & ((instruction[J_LT] & alu_ng) |
                        (instruction[J_EQ] & alu_zr) |
                        (instruction[J_GT] & ~alu_ng & ~alu_zr));

        a_d = a_q;
        d_d = d_q;
        if (!is_c) begin
            a_d = instruction;
        end else begin
            if (instruction[DEST_A]) a_d = alu_out;
            if (instruction[DEST_D]) d_d = alu_out;
        end

        // Jump target is the old A, so "A=...;JMP" lands where A pointed before.
        pc_d = take ? a_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
    end

    // Architectural state update; reset clears everything immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q  <= '0;
            d_q  <= '0;
            pc_q <= '0;
        end else begin
            a_q  <= a_d;
            d_q  <= d_d;
            pc_q <= pc_d;
        end
    end

    assign outM     = alu_out;
    assign writeM   = is_c & instruction[DEST_M] & reset_n;
    assign addressM = a_q[ADDR_W-1:0];
    assign pc       = pc_q;

`ifdef HACK_CPU_DEBUG_EN
    assign dbg_a    = a_q;
    assign dbg_d    = d_q;
    assign dbg_jump = take;
`endif
endmodule

// File: tb/tb_hack_cpu.sv
// Self-checking bench for hack_cpu against a behavioural Hack machine model.
module tb_hack_cpu;
    logic        clock;
    logic        reset_n;
    logic [15:0] instruction;
    logic [15:0] inM;
    logic [15:0] outM;
    logic        writeM;
    logic [14:0] addressM;
    logic [14:0] pc;
`ifdef HACK_CPU_DEBUG_EN
    logic [15:0] dbg_a, dbg_d;
    logic        dbg_jump;
`endif

    int checks = 0;
    int errors = 0;

    // Model state
    int mA, mD, mPC;

    hack_cpu #(.ADDR_W(15)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instruction (instruction),
        .inM         (inM),
        .outM        (outM),
        .writeM      (writeM),
        .addressM    (addressM),
`ifdef HACK_CPU_DEBUG_EN
        .dbg_a       (dbg_a),
        .dbg_d       (dbg_d),
        .dbg_jump    (dbg_jump),
`endif
        .pc          (pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hack computation in plain integer arithmetic.
    function automatic int model_comp(input int ins, input int m);
        int x, y, o;
        x = mD;
        y = ((ins >> 12) & 1) ? m : mA;
        if ((ins >> 11) & 1) x = 0;
        if ((ins >> 10) & 1) x = 65535 - x;
        if ((ins >> 9) & 1)  y = 0;
        if ((ins >> 8) & 1)  y = 65535 - y;
        if ((ins >> 7) & 1)  o = (x + y) % 65536;
        else                 o = x & y;
        if ((ins >> 6) & 1)  o = 65535 - o;
        return o;
    endfunction

    function automatic int model_sval(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    function automatic bit model_take(input int ins, input int m);
        int s;
        if (((ins >> 15) & 1) == 0) return 1'b0;
        s = model_sval(model_comp(ins, m));
        return (((ins >> 2) & 1) && s < 0) || (((ins >> 1) & 1) && s == 0) ||
               ((ins & 1) && s > 0);
    endfunction

    function automatic bit model_wr(input int ins);
        return ((ins >> 15) & 1) && ((ins >> 3) & 1);
    endfunction

    // Drive one instruction at the falling edge and let combinational outputs settle.
    task automatic apply(input logic [15:0] ins, input logic [15:0] m);
        instruction = ins;
        inM = m;
        #1;
    endtask

    // Advance the model by the current instruction and clock the DUT once.
    task automatic tick();
        int ins, m, r, nA, nD, nPC;
        ins = int'(instruction);
        m   = int'(inM);
        nA = mA; nD = mD;
        if (((ins >> 15) & 1) == 0) begin
            nA = ins;
        end else begin
            r = model_comp(ins, m);
            if ((ins >> 5) & 1) nA = r;
            if ((ins >> 4) & 1) nD = r;
        end
        nPC = model_take(ins, m) ? (mA % 32768) : (mPC + 1) % 32768;
        mA = nA; mD = nD; mPC = nPC;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        instruction = 16'hE308;
        inM = 16'h0000;
        mA = 0; mD = 0; mPC = 0;
        #12;
        checks++;
        if (pc !== 15'd0) begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
        checks++;
        if (addressM !== 15'd0) begin errors++; $display("FAIL reset_addr got %h want 0", addressM); end
        checks++;
        if (writeM !== 1'b0) begin errors++; $display("FAIL reset_writeM got %b want 0", writeM); end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++;
        if (pc !== 15'd0) begin errors++; $display("FAIL release_pc got %h want 0", pc); end
    endtask

    task automatic test_a_then_d();
        apply(16'h0005, 16'h0);
        tick();
        checks++;
        if (addressM !== 15'd5 || pc !== 15'd1) begin
            errors++; $display("FAIL a_instr addr=%h pc=%h want 5,1", addressM, pc);
        end
        apply(16'hEC10, 16'h0);
        tick();
        apply(16'hE300, 16'h0);
        checks++;
        if (outM !== 16'd5) begin errors++; $display("FAIL d_eq_a D=%h want 5", outM); end
        apply(16'hE090, 16'h0);
        tick();
        apply(16'hE300, 16'h0);
        checks++;
        if (outM !== 16'd10 || pc !== 15'd3) begin
            errors++; $display("FAIL d_plus_a D=%h pc=%h want 000a,3", outM, pc);
        end
    endtask

    task automatic test_mem_write();
        apply(16'hE308, 16'h0);
        checks++;
        if (writeM !== 1'b1 || outM !== 16'd10 || addressM !== 15'd5) begin
            errors++; $display("FAIL mem_write wr=%b out=%h addr=%h want 1,000a,5", writeM, outM, addressM);
        end
        tick();
        apply(16'h0005, 16'h0);
        checks++;
        if (writeM !== 1'b0) begin errors++; $display("FAIL a_instr_writeM got %b want 0", writeM); end
        tick();
    endtask

    task automatic test_mem_source();
        apply(16'hFC10, 16'h1234);
        tick();
        apply(16'hE300, 16'h0);
        checks++;
        if (outM !== 16'h1234) begin errors++; $display("FAIL d_eq_m D=%h want 1234", outM); end
        apply(16'h0001, 16'h0); tick();
        apply(16'hEC10, 16'h0); tick();
        apply(16'hF1D0, 16'h1234); tick();
        apply(16'hE300, 16'h0);
        checks++;
        if (outM !== 16'h1233) begin errors++; $display("FAIL m_minus_d D=%h want 1233", outM); end
    endtask

    task automatic test_jumps();
        int p;
        apply(16'h0010, 16'h0); tick();
        apply(16'hEA87, 16'h0); tick();
        checks++;
        if (pc !== 15'h0010) begin errors++; $display("FAIL jmp pc=%h want 0010", pc); end
        apply(16'hEA90, 16'h0); tick();
        p = int'(pc);
        apply(16'hE301, 16'h0); tick();
        checks++;
        if (int'(pc) !== p + 1) begin errors++; $display("FAIL jgt_zero pc=%h want %h", pc, p + 1); end
        apply(16'hE302, 16'h0); tick();
        checks++;
        if (pc !== 15'h0010) begin errors++; $display("FAIL jeq_zero pc=%h want 0010", pc); end
    endtask

    task automatic test_wrap_simul();
        apply(16'h7FFF, 16'h0); tick();
        apply(16'hEA87, 16'h0); tick();
        checks++;
        if (pc !== 15'h7FFF) begin errors++; $display("FAIL jmp_top pc=%h want 7fff", pc); end
        apply(16'h0020, 16'h0); tick();
        checks++;
        if (pc !== 15'h0000) begin errors++; $display("FAIL pc_wrap pc=%h want 0000", pc); end
        apply(16'hEFE7, 16'h0); tick();
        checks++;
        if (pc !== 15'h0020 || addressM !== 15'd1) begin
            errors++; $display("FAIL a_write_jmp pc=%h addr=%h want 0020,1", pc, addressM);
        end
        // M write together with A write stores to the old A.
        apply(16'h0044, 16'h0); tick();
        apply(16'hEFE8, 16'h0);
        checks++;
        if (writeM !== 1'b1 || addressM !== 15'h44 || outM !== 16'd1) begin
            errors++; $display("FAIL am_write wr=%b addr=%h out=%h want 1,0044,0001", writeM, addressM, outM);
        end
        tick();
    endtask

    task automatic test_random();
        logic [15:0] ins, m;
        for (int i = 0; i < 300; i++) begin
            ins = 16'($urandom);
            m   = 16'($urandom);
            apply(ins, m);
            checks++;
            if (int'(pc) !== mPC || int'(addressM) !== (mA % 32768) ||
                int'(outM) !== model_comp(int'(ins), int'(m)) || writeM !== model_wr(int'(ins))) begin
                errors++;
                $display("FAIL random[%0d] ins=%h pc=%h/%h addr=%h/%h out=%h/%h wr=%b/%b", i, ins,
                         pc, mPC, addressM, mA % 32768, outM, model_comp(int'(ins), int'(m)),
                         writeM, model_wr(int'(ins)));
            end
`ifdef HACK_CPU_DEBUG_EN
            checks++;
            if (int'(dbg_a) !== mA || int'(dbg_d) !== mD || dbg_jump !== model_take(int'(ins), int'(m))) begin
                errors++; $display("FAIL dbg a=%h/%h d=%h/%h j=%b", dbg_a, mA, dbg_d, mD, dbg_jump);
            end
`endif
            tick();
        end
    endtask

    task automatic test_reset_mid();
        apply(16'h0123, 16'h0); tick();
        apply(16'hEA90, 16'h0); tick();
        apply(16'hE308, 16'h0);
        #2;
        reset_n = 1'b0;
        #1;
        mA = 0; mD = 0; mPC = 0;
        checks++;
        if (pc !== 15'd0 || addressM !== 15'd0 || writeM !== 1'b0) begin
            errors++; $display("FAIL reset_mid pc=%h addr=%h wr=%b want 0,0,0", pc, addressM, writeM);
        end
        @(negedge clock);
        reset_n = 1'b1;
        apply(16'h0003, 16'h0);
        checks++;
        if (pc !== 15'd0) begin errors++; $display("FAIL first_fetch pc=%h want 0", pc); end
        tick();
        checks++;
        if (pc !== 15'd1 || addressM !== 15'd3) begin
            errors++; $display("FAIL post_reset pc=%h addr=%h want 1,3", pc, addressM);
        end
    endtask

    initial begin
        test_reset();
        test_a_then_d();
        test_mem_write();
        test_mem_source();
        test_jumps();
        test_wrap_simul();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
